id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode-to-execute boundary of the 5-stage pipeline. Sits directly downstream of the register file's read ports (qa/qb).
- Selects each source operand from one of four places: the register file, or forwarded EX, MEM or WB results.
- Detects load-use hazards and produces the stall to IF/ID.
- Holds the ID/EX pipeline register, with bubble insertion and flush.

Parameters:
- DW, 32, datapath width
- AW, 5, register-number width
- CW, 16, stall-counter width (saturating)

Ports:
- clk  in  1  pipeline clock, all state updates on posedge
- clr  in  1  synchronous active-high reset
- d_valid  in  1  ID holds a real instruction
- d_rs, d_rt  in  AW  source register numbers (also drive regfile rna/rnb)
- d_use_rs, d_use_rt  in  1  instruction actually reads rs/rt
- d_qa, d_qb  in  DW  regfile read data
- d_imm  in  DW  extended immediate
- d_wn  in  AW  destination register
- d_wreg, d_m2reg, d_wmem, d_aluimm  in  1  decoded controls
- d_aluc  in  4  ALU op
- ex_wn  in  AW  EX-stage destination
- ex_wreg, ex_m2reg  in  1  EX-stage write and load flags
- ex_alu  in  DW  EX-stage ALU result
- mem_wn  in  AW  MEM-stage destination
- mem_wreg, mem_m2reg  in  1  MEM-stage write and load flags
- mem_alu  in  DW  MEM-stage ALU result
- mem_dmo  in  DW  MEM-stage load data
- wb_wn  in  AW  WB destination (same as regfile wn)
- wb_we  in  1  WB write enable
- wb_d  in  DW  WB write data
- flush  in  1  squash the ID instruction (taken branch/jump)
- stall  out  1  hold PC and IF/ID; combinational
- e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm  out  1  registered controls
- e_aluc  out  4  registered ALU op
- e_wn  out  AW  registered destination
- e_a, e_b, e_imm  out  DW  registered operands
- stall_cnt  out  CW  saturating count of stall cycles

Behaviour:
- Reset:
  - clr is sampled at posedge clk only.
  - All e_* outputs and stall_cnt go to 0.
  - stall is 0 while clr is high.
- Forward select, evaluated per operand (rs→a, rt→b) in priority order:
  1. Register number 0 always yields 0. It is never forwarded or compared.
  2. EX hit: ex_wreg & !ex_m2reg & ex_wn==r yields ex_alu.
  3. MEM hit: mem_wreg & mem_wn==r yields mem_dmo if mem_m2reg, otherwise mem_alu.
  4. WB hit: wb_we & wb_wn==r yields wb_d. This is needed because the register file writes at the same edge, so its read data is stale for one cycle.
  5. Otherwise d_qa/d_qb.
- Load-use hazard: ex_wreg & ex_m2reg & ex_wn!=0 & ((d_use_rs & ex_wn==d_rs) | (d_use_rt & ex_wn==d_rt)).
- Stall: stall = d_valid & !flush & !clr & hazard. The stall lasts exactly one cycle per load, because the load has moved to MEM on the next cycle.
- Next-state priority at posedge:
  1. clr: everything is 0.
  2. flush or stall or !d_valid: bubble. e_valid, e_wreg and e_wmem are 0; the other e_* fields are also 0, so bubbles are deterministic.
  3. Otherwise: capture the d_* controls, the selected operands, and d_imm.
- Stall counter: stall_cnt increments on every cycle where stall is 1, and saturates at all-ones without wrapping.
- Simultaneous events:
  - flush wins over stall.
  - An EX hit wins over a MEM hit, which wins over a WB hit, for the same register.
  - An operand that is not used still takes the forwarded value, which is harmless. It never causes a stall.
- No stall and no forwarding are attached to d_wn or to stores, other than through rt.
- Latency: one cycle from ID inputs to e_* outputs.

Decomposition:
- Shared package holds:
  - ALUC_W = 4
  - REG_ZERO = 0
  - the bubble control constant
  - a ctrl bundle struct {wreg, m2reg, wmem, aluimm, aluc}
- One sub-module is natural: fwd_mux.
  - Instantiated twice, once for a and once for b.
  - Inputs: register number, regfile data, and the EX/MEM/WB taps.
  - Output: the selected operand.
  - Purely combinational.

Test Plan:
- Reset: assert clr for 2 cycles with d_valid=1 → e_valid=0, e_a=0, stall_cnt=0, stall=0.
- EX forwarding:
  - Stimulus: ex_wn=3, ex_wreg=1, ex_alu=0xAAAA0001; mem_wn=3, mem_alu=0xBBBB; d_rs=3, d_qa=3.
  - Response: next cycle e_a=0xAAAA0001, since EX wins over MEM.
- WB forwarding:
  - Stimulus: wb_we=1, wb_wn=5, wb_d=0x55; d_rt=5, d_qb=5.
  - Response: e_b=0x55.
  - Then set d_rt=0 with wb_wn=0 → e_b=0.
- Load-use:
  - Stimulus: ex_m2reg=1, ex_wreg=1, ex_wn=4; d_rs=4, d_use_rs=1.
  - Response: stall=1 for one cycle, bubble in e_*, stall_cnt=1.
  - Next cycle: with load in MEM (mem_m2reg=1, mem_dmo=0x1234) → stall=0, e_a=0x1234.
- Same hazard but d_use_rs=0 → stall=0, no bubble, stall_cnt unchanged.
- Same hazard with flush=1 → stall=0, e_valid=0.
- Force 2^CW+3 stall cycles → stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX boundary: control bundle and bubble value.
package id_ex_stage_pkg;
  localparam int ALUC_W   = 4;
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic              aluimm;
    logic [ALUC_W-1:0] aluc;
  } ctrl_t;

  // A bubble carries no side effects and all-zero payload so it is deterministic.
  localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX bus: decoded ID inputs, EX/MEM/WB forwarding taps, registered EX outputs.
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
) ();
  logic              d_valid;
  logic [AW-1:0]     d_rs, d_rt, d_wn;
  logic              d_use_rs, d_use_rt;
  logic [DW-1:0]     d_qa, d_qb, d_imm;
  logic              d_wreg, d_m2reg, d_wmem, d_aluimm;
  logic [ALUC_W-1:0] d_aluc;
  logic [AW-1:0]     ex_wn, mem_wn, wb_wn;
  logic              ex_wreg, ex_m2reg, mem_wreg, mem_m2reg, wb_we;
  logic [DW-1:0]     ex_alu, mem_alu, mem_dmo, wb_d;
  logic              flush;
  logic              stall;
  logic              e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm;
  logic [ALUC_W-1:0] e_aluc;
  logic [AW-1:0]     e_wn;
  logic [DW-1:0]     e_a, e_b, e_imm;
  logic [CW-1:0]     stall_cnt;

  modport master (
    output d_valid, d_rs, d_rt, d_wn, d_use_rs, d_use_rt, d_qa, d_qb, d_imm,
           d_wreg, d_m2reg, d_wmem, d_aluimm, d_aluc,
           ex_wn, ex_wreg, ex_m2reg, ex_alu, mem_wn, mem_wreg, mem_m2reg,
           mem_alu, mem_dmo, wb_wn, wb_we, wb_d, flush,
    input  stall, e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_aluc, e_wn,
           e_a, e_b, e_imm, stall_cnt
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_wn, d_use_rs, d_use_rt, d_qa, d_qb, d_imm,
           d_wreg, d_m2reg, d_wmem, d_aluimm, d_aluc,
           ex_wn, ex_wreg, ex_m2reg, ex_alu, mem_wn, mem_wreg, mem_m2reg,
           mem_alu, mem_dmo, wb_wn, wb_we, wb_d, flush,
    output stall, e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_aluc, e_wn,
           e_a, e_b, e_imm, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand source select: r0, EX, MEM, WB forward, else register file data.
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] i_rn,
  input  logic [DW-1:0] i_q,
  input  logic [AW-1:0] i_ex_wn,
  input  logic          i_ex_wreg,
  input  logic          i_ex_m2reg,
  input  logic [DW-1:0] i_ex_alu,
  input  logic [AW-1:0] i_mem_wn,
  input  logic          i_mem_wreg,
  input  logic          i_mem_m2reg,
  input  logic [DW-1:0] i_mem_alu,
  input  logic [DW-1:0] i_mem_dmo,
  input  logic [AW-1:0] i_wb_wn,
  input  logic          i_wb_we,
  input  logic [DW-1:0] i_wb_d,
  output logic [DW-1:0] o_d
);
  logic w_zero, w_ex_hit, w_mem_hit, w_wb_hit;

  assign w_zero    = (i_rn == AW'(REG_ZERO));
  // A load in EX has no data yet; that case is covered by the stall instead.
  assign w_ex_hit  = i_ex_wreg & ~i_ex_m2reg & (i_ex_wn == i_rn);
  assign w_mem_hit = i_mem_wreg & (i_mem_wn == i_rn);
  // Regfile writes on the same edge, so its read data lags WB by a cycle.
  assign w_wb_hit  = i_wb_we & (i_wb_wn == i_rn);

  always_comb begin
    o_d = i_q;
    if (w_zero)         o_d = '0;
    else if (w_ex_hit)  o_d = i_ex_alu;
    else if (w_mem_hit) o_d = i_mem_m2reg ? i_mem_dmo : i_mem_alu;
    else if (w_wb_hit)  o_d = i_wb_d;
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall and flush bubbles.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input logic         clk,
  input logic         clr,
  id_ex_stage_if.slave bus
);
  logic [DW-1:0] w_a, w_b;
  logic          w_hazard, w_stall, w_bubble;
  ctrl_t         w_dctrl;

  logic          r_valid;
  ctrl_t         r_ctrl;
  logic [AW-1:0] r_wn;
  logic [DW-1:0] r_a, r_b, r_imm;
  logic [CW-1:0] r_stall_cnt;

  id_ex_stage_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_a (
    .i_rn(bus.d_rs), .i_q(bus.d_qa),
    .i_ex_wn(bus.ex_wn), .i_ex_wreg(bus.ex_wreg), .i_ex_m2reg(bus.ex_m2reg),
    .i_ex_alu(bus.ex_alu),
    .i_mem_wn(bus.mem_wn), .i_mem_wreg(bus.mem_wreg), .i_mem_m2reg(bus.mem_m2reg),
    .i_mem_alu(bus.mem_alu), .i_mem_dmo(bus.mem_dmo),
    .i_wb_wn(bus.wb_wn), .i_wb_we(bus.wb_we), .i_wb_d(bus.wb_d),
    .o_d(w_a)
  );

  id_ex_stage_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_b (
    .i_rn(bus.d_rt), .i_q(bus.d_qb),
    .i_ex_wn(bus.ex_wn), .i_ex_wreg(bus.ex_wreg), .i_ex_m2reg(bus.ex_m2reg),
    .i_ex_alu(bus.ex_alu),
    .i_mem_wn(bus.mem_wn), .i_mem_wreg(bus.mem_wreg), .i_mem_m2reg(bus.mem_m2reg),
    .i_mem_alu(bus.mem_alu), .i_mem_dmo(bus.mem_dmo),
    .i_wb_wn(bus.wb_wn), .i_wb_we(bus.wb_we), .i_wb_d(bus.wb_d),
    .o_d(w_b)
  );

  // One stall cycle suffices: next cycle the load sits in MEM and forwards mem_dmo.
  assign w_hazard = bus.ex_wreg & bus.ex_m2reg & (bus.ex_wn != AW'(REG_ZERO)) &
                    ((bus.d_use_rs & (bus.ex_wn == bus.d_rs)) |
                     (bus.d_use_rt & (bus.ex_wn == bus.d_rt)));
  assign w_stall  = bus.d_valid & ~bus.flush & ~clr & w_hazard;
  assign w_bubble = bus.flush | w_stall | ~bus.d_valid;

  assign w_dctrl.wreg   = bus.d_wreg;
  assign w_dctrl.m2reg  = bus.d_m2reg;
  assign w_dctrl.wmem   = bus.d_wmem;
  assign w_dctrl.aluimm = bus.d_aluimm;
  assign w_dctrl.aluc   = bus.d_aluc;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_valid     <= 1'b0;
      r_ctrl      <= CTRL_BUBBLE;
      r_wn        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_imm       <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_bubble) begin
        r_valid <= 1'b0;
        r_ctrl  <= CTRL_BUBBLE;
        r_wn    <= '0;
        r_a     <= '0;
        r_b     <= '0;
        r_imm   <= '0;
      end else begin
        r_valid <= 1'b1;
        r_ctrl  <= w_dctrl;
        r_wn    <= bus.d_wn;
        r_a     <= w_a;
        r_b     <= w_b;
        r_imm   <= bus.d_imm;
      end
      if (w_stall && (r_stall_cnt != {CW{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CW'(1);
    end
  end

  assign bus.stall     = w_stall;
  assign bus.e_valid   = r_valid;
  assign bus.e_wreg    = r_ctrl.wreg;
  assign bus.e_m2reg   = r_ctrl.m2reg;
  assign bus.e_wmem    = r_ctrl.wmem;
  assign bus.e_aluimm  = r_ctrl.aluimm;
  assign bus.e_aluc    = r_ctrl.aluc;
  assign bus.e_wn      = r_wn;
  assign bus.e_a       = r_a;
  assign bus.e_b       = r_b;
  assign bus.e_imm     = r_imm;
  assign bus.stall_cnt = r_stall_cnt;
endmodule
